// File: rtl/quad_decoder_counter_if.sv
// Bus bundle for one quadrature decoder/counter: raw encoder pins, control
// strobes and the decoded position outputs.
interface quad_decoder_counter_if #(
  parameter int WIDTH = 16
);
  logic             A;
  logic             B;
  logic             Z;
  logic             enable;
  logic             index_en;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear_err;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  modport master (
    output A, B, Z, enable, index_en, load, load_value, clear_err,
    input  count, dir, step, err
  );

  modport slave (
    input  A, B, Z, enable, index_en, load, load_value, clear_err,
    output count, dir, step, err
  );
endinterface

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder and signed position counter for one joint encoder.
// Raw A/B/Z pins are synchronised and glitch-filtered, then {A,B} is decoded
// at x1/x2/x4 resolution into a wrapping or saturating position count with
// preload, index zeroing and a sticky illegal-transition flag.
module quad_decoder_counter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int MODE        = 2,
  parameter int SATURATE    = 0
) (
  input logic                  CLK,
  input logic                  RST,
  quad_decoder_counter_if.slave bus
);

  localparam logic [7:0]       FLEN    = 8'(FILTER_LEN);
  localparam logic [2:0]       WARM    = 3'(SYNC_STAGES);
  localparam logic [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Channel bit order everywhere: [2]=A, [1]=B, [0]=Z.
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       sync_d [SYNC_STAGES];
  logic [2:0]       sync_out;
  logic [2:0]       filt_q, filt_d;
  logic [7:0]       run_q [3];
  logic [7:0]       run_d [3];
  logic [2:0]       warm_q, warm_d;
  logic             primed_q, primed_d;
  logic [1:0]       prev_ab_q, prev_ab_d;
  logic             prev_z_q, prev_z_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  logic [3:0]       trans;
  logic [1:0]       diff;
  logic             x4_up, x4_dn;
  logic             ev_up, ev_dn;
  logic             illegal;
  logic             z_rise;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw pins through the synchroniser chain.
  always_comb begin
    sync_d[0] = {bus.A, bus.B, bus.Z};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Per-channel run-length filter; before priming the filter is seeded
  // straight from the synchroniser so the idle pin state is absorbed.
  always_comb begin
    filt_d = filt_q;
    for (int ch = 0; ch < 3; ch++) begin
      run_d[ch] = run_q[ch];
      if (!primed_q) begin
        filt_d[ch] = sync_out[ch];
        run_d[ch]  = '0;
      end else if (sync_out[ch] == filt_q[ch]) begin
        run_d[ch] = '0;
      end else if (run_q[ch] == FLEN) begin
        filt_d[ch] = sync_out[ch];
        run_d[ch]  = '0;
      end else begin
        run_d[ch] = run_q[ch] + 8'd1;
      end
    end
  end

  // Priming waits until the synchroniser holds real pin samples, then
  // snapshots them as the previous state; afterwards prev tracks the filter.
  always_comb begin
    primed_d  = primed_q;
    warm_d    = warm_q;
    prev_ab_d = filt_q[2:1];
    prev_z_d  = filt_q[0];
    if (!primed_q) begin
      if (warm_q == WARM) begin
        primed_d  = 1'b1;
        prev_ab_d = sync_out[2:1];
        prev_z_d  = sync_out[0];
      end else begin
        warm_d = warm_q + 3'd1;
      end
    end
  end

  // Classify the previous->current {A,B} pair and apply the resolution mode.
  always_comb begin
    trans   = {prev_ab_q, filt_q[2:1]};
    diff    = prev_ab_q ^ filt_q[2:1];
    x4_up   = (trans == 4'b0001) || (trans == 4'b0111) ||
              (trans == 4'b1110) || (trans == 4'b1000);
    x4_dn   = (trans == 4'b0100) || (trans == 4'b1101) ||
              (trans == 4'b1011) || (trans == 4'b0010);
    illegal = primed_q && (diff == 2'b11);
    z_rise  = primed_q && filt_q[0] && !prev_z_q;
    if (MODE == 0) begin
      ev_up = primed_q && (trans == 4'b0111);
      ev_dn = primed_q && (trans == 4'b0010);
    end else if (MODE == 1) begin
      ev_up = primed_q && x4_up && diff[1];
      ev_dn = primed_q && x4_dn && diff[1];
    end else begin
      ev_up = primed_q && x4_up;
      ev_dn = primed_q && x4_dn;
    end
  end

  // Position update: load beats index zeroing, which beats a decode event.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (bus.load) begin
      count_d = bus.load_value;
    end else if (bus.index_en && z_rise) begin
      count_d = '0;
    end else if (bus.enable && (ev_up || ev_dn)) begin
      step_d = 1'b1;
      dir_d  = ev_up;
      if (ev_up) begin
        if ((SATURATE != 0) && (count_q == CNT_MAX)) count_d = count_q;
        else count_d = count_q + WIDTH'(1);
      end else begin
        if ((SATURATE != 0) && (count_q == CNT_MIN)) count_d = count_q;
        else count_d = count_q - WIDTH'(1);
      end
    end
    err_d = illegal ? 1'b1 : (bus.clear_err ? 1'b0 : err_q);
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int ch = 0; ch < 3; ch++) run_q[ch] <= '0;
      filt_q    <= '0;
      warm_q    <= '0;
      primed_q  <= 1'b0;
      prev_ab_q <= '0;
      prev_z_q  <= 1'b0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      for (int ch = 0; ch < 3; ch++) run_q[ch] <= run_d[ch];
      filt_q    <= filt_d;
      warm_q    <= warm_d;
      primed_q  <= primed_d;
      prev_ab_q <= prev_ab_d;
      prev_z_q  <= prev_z_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Bench for quad_decoder_counter: five instances (x4, x2, x1, 4-bit wrap,
// 4-bit saturate) share the same pin stimulus. Every step pulse of the x4
// instance is scored against a queue of hand-computed expectations that
// includes the cycle the pulse must appear on.
module tb_quad_decoder_counter;

  typedef struct {
    int cnt;
    int dir;
    int cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst_drv = 1'b1;
  logic        a_drv = 1'b0, b_drv = 1'b0, z_drv = 1'b0;
  logic        en_drv = 1'b1, idx_drv = 1'b0, load_drv = 1'b0, clr_drv = 1'b0;
  logic [15:0] lv_drv = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          exp_count = 0;
  exp_t        exp_q[$];

  quad_decoder_counter_if #(.WIDTH(16)) if_x4 ();
  quad_decoder_counter_if #(.WIDTH(16)) if_x2 ();
  quad_decoder_counter_if #(.WIDTH(16)) if_x1 ();
  quad_decoder_counter_if #(.WIDTH(4))  if_w  ();
  quad_decoder_counter_if #(.WIDTH(4))  if_s  ();

  assign if_x4.A = a_drv;  assign if_x4.B = b_drv;  assign if_x4.Z = z_drv;
  assign if_x4.enable = en_drv;  assign if_x4.index_en = idx_drv;
  assign if_x4.load = load_drv;  assign if_x4.load_value = lv_drv;
  assign if_x4.clear_err = clr_drv;
  assign if_x2.A = a_drv;  assign if_x2.B = b_drv;  assign if_x2.Z = z_drv;
  assign if_x2.enable = en_drv;  assign if_x2.index_en = idx_drv;
  assign if_x2.load = load_drv;  assign if_x2.load_value = lv_drv;
  assign if_x2.clear_err = clr_drv;
  assign if_x1.A = a_drv;  assign if_x1.B = b_drv;  assign if_x1.Z = z_drv;
  assign if_x1.enable = en_drv;  assign if_x1.index_en = idx_drv;
  assign if_x1.load = load_drv;  assign if_x1.load_value = lv_drv;
  assign if_x1.clear_err = clr_drv;
  assign if_w.A = a_drv;  assign if_w.B = b_drv;  assign if_w.Z = z_drv;
  assign if_w.enable = en_drv;  assign if_w.index_en = idx_drv;
  assign if_w.load = load_drv;  assign if_w.load_value = lv_drv[3:0];
  assign if_w.clear_err = clr_drv;
  assign if_s.A = a_drv;  assign if_s.B = b_drv;  assign if_s.Z = z_drv;
  assign if_s.enable = en_drv;  assign if_s.index_en = idx_drv;
  assign if_s.load = load_drv;  assign if_s.load_value = lv_drv[3:0];
  assign if_s.clear_err = clr_drv;

  quad_decoder_counter #(.WIDTH(16), .MODE(2)) u_x4 (.CLK(CLK), .RST(rst_drv), .bus(if_x4));
  quad_decoder_counter #(.WIDTH(16), .MODE(1)) u_x2 (.CLK(CLK), .RST(rst_drv), .bus(if_x2));
  quad_decoder_counter #(.WIDTH(16), .MODE(0)) u_x1 (.CLK(CLK), .RST(rst_drv), .bus(if_x1));
  quad_decoder_counter #(.WIDTH(4), .MODE(2), .SATURATE(0)) u_w (.CLK(CLK), .RST(rst_drv), .bus(if_w));
  quad_decoder_counter #(.WIDTH(4), .MODE(2), .SATURATE(1)) u_s (.CLK(CLK), .RST(rst_drv), .bus(if_s));

  always #5 CLK = ~CLK;

  // Cycle index used to pin down when each step pulse must appear.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Queue the response of the x4 instance: a level driven at negedge N is
  // sampled at posedge N+1 and must show up as a step 7 edges later.
  task automatic push_exp(input int delta);
    exp_t e;
    exp_count += delta;
    e.cnt = exp_count;
    e.dir = (delta > 0) ? 1 : 0;
    e.cyc = cyc + 8;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic a, input logic b, input int delta, input int hold);
    @(negedge CLK);
    a_drv = a;
    b_drv = b;
    if (delta != 0) push_exp(delta);
    repeat (hold - 1) @(negedge CLK);
  endtask

  // Scoreboard monitor: every step pulse pops and checks one expectation.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!rst_drv && if_x4.step) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_step: count=%0d at cycle %0d, expected no step",
                   $signed(if_x4.count), cyc);
        end else begin
          e = exp_q.pop_front();
          if ($signed(if_x4.count) != e.cnt || int'(if_x4.dir) != e.dir || cyc != e.cyc) begin
            bad++;
            $display("[TB] FAIL step_event: got count=%0d dir=%0d cycle=%0d, expected count=%0d dir=%0d cycle=%0d",
                     $signed(if_x4.count), if_x4.dir, cyc, e.cnt, e.dir, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset with both channels high: priming must absorb the idle 11 state.
    a_drv = 1'b1;
    b_drv = 1'b1;
    repeat (3) @(negedge CLK);
    check_output("reset_count", $signed(if_x4.count), 0);
    rst_drv = 1'b0;
    repeat (20) @(negedge CLK);
    check_output("prime_count", $signed(if_x4.count), 0);
    check_output("prime_err", int'(if_x4.err), 0);

    // Restart from 00 for the counting sequences.
    rst_drv = 1'b1;
    a_drv = 1'b0;
    b_drv = 1'b0;
    exp_count = 0;
    repeat (3) @(negedge CLK);
    rst_drv = 1'b0;
    repeat (10) @(negedge CLK);

    // Eight full forward cycles.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b1, 1, 10);
      apply_stimulus(1'b1, 1'b1, 1, 10);
      apply_stimulus(1'b1, 1'b0, 1, 10);
      apply_stimulus(1'b0, 1'b0, 1, 10);
    end
    check_output("x4_up_count", $signed(if_x4.count), 32);
    check_output("x4_up_dir", int'(if_x4.dir), 1);
    check_output("x2_up_count", $signed(if_x2.count), 16);
    check_output("x1_up_count", $signed(if_x1.count), 8);

    // Three reverse cycles.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, -1, 10);
      apply_stimulus(1'b1, 1'b1, -1, 10);
      apply_stimulus(1'b0, 1'b1, -1, 10);
      apply_stimulus(1'b0, 1'b0, -1, 10);
    end
    check_output("x4_dn_count", $signed(if_x4.count), 20);
    check_output("x4_dn_dir", int'(if_x4.dir), 0);
    check_output("x2_dn_count", $signed(if_x2.count), 10);
    check_output("x1_dn_count", $signed(if_x1.count), 5);

    // 3-cycle glitch on A is swallowed; 5-cycle pulse on B counts up then down.
    apply_stimulus(1'b1, 1'b0, 0, 3);
    apply_stimulus(1'b0, 1'b0, 0, 12);
    check_output("glitch_count", $signed(if_x4.count), 20);
    apply_stimulus(1'b0, 1'b1, 1, 5);
    apply_stimulus(1'b0, 1'b0, -1, 12);
    check_output("pulse_count", $signed(if_x4.count), 20);

    // Both channels flip together: sticky err, count untouched.
    apply_stimulus(1'b1, 1'b1, 0, 10);
    check_output("illegal_err", int'(if_x4.err), 1);
    check_output("illegal_count", $signed(if_x4.count), 20);
    apply_stimulus(1'b0, 1'b0, 0, 10);
    check_output("illegal_err_sticky", int'(if_x4.err), 1);
    @(negedge CLK);
    clr_drv = 1'b1;
    @(negedge CLK);
    clr_drv = 1'b0;
    check_output("clear_err", int'(if_x4.err), 0);

    // Preload.
    @(negedge CLK);
    load_drv = 1'b1;
    lv_drv = 16'd100;
    @(negedge CLK);
    load_drv = 1'b0;
    exp_count = 100;
    check_output("load_count", $signed(if_x4.count), 100);
    check_output("load_step", int'(if_x4.step), 0);

    // Index rising edge lands on the same cycle as an up transition.
    idx_drv = 1'b1;
    @(negedge CLK);
    z_drv = 1'b1;
    b_drv = 1'b1;
    repeat (10) @(negedge CLK);
    exp_count = 0;
    check_output("index_count", $signed(if_x4.count), 0);
    check_output("index_dir", int'(if_x4.dir), 0);
    idx_drv = 1'b0;
    z_drv = 1'b0;
    repeat (10) @(negedge CLK);

    // 4-bit counters at +7 take one up step: wrap vs clamp.
    @(negedge CLK);
    load_drv = 1'b1;
    lv_drv = 16'd7;
    @(negedge CLK);
    load_drv = 1'b0;
    exp_count = 7;
    @(negedge CLK);
    a_drv = 1'b1;
    push_exp(1);
    repeat (8) @(negedge CLK);
    check_output("wrap_count", $signed(if_w.count), -8);
    check_output("wrap_step", int'(if_w.step), 1);
    check_output("sat_count", $signed(if_s.count), 7);
    check_output("sat_step", int'(if_s.step), 1);
    check_output("sat_dir", int'(if_s.dir), 1);
    repeat (4) @(negedge CLK);

    // Asynchronous reset mid-run clears at once; re-prime with A=B=1 is silent.
    #2;
    rst_drv = 1'b1;
    #1;
    check_output("async_reset_count", $signed(if_x4.count), 0);
    exp_count = 0;
    repeat (3) @(negedge CLK);
    rst_drv = 1'b0;
    repeat (20) @(negedge CLK);
    check_output("reprime_count", $signed(if_x4.count), 0);
    check_output("reprime_err", int'(if_x4.err), 0);

    // Every queued step must have been seen within a bounded wait.
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge CLK);
    check_output("scoreboard_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
